// File: rtl/us_timming_flow_receiver.sv
// Flow-word receiver: a small register skid buffer in front of a write-only FIFO,
// with frame tracking (done/abort pulses, per-frame word count) and drop statistics.
module us_timming_flow_receiver #(
  parameter int DATA_W         = 128,
  parameter int BUF_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic              us_timming_flow_vld_i,
  input  logic [DATA_W-1:0] us_timming_flow_i,
  input  logic              transmit_done_pluse_i,
  output logic              us_timming_wr_en_o,
  output logic [DATA_W-1:0] us_timming_din_o,
  input  logic              us_timming_full_i,
  output logic              frame_done_pluse_o,
  output logic [11:0]       frame_word_cnt_o,
  output logic              frame_abort_pluse_o,
  output logic              overflow_o,
  output logic [15:0]       drop_cnt_o,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(BUF_DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W-1:0]   occ_next;
  logic [OCC_W-1:0]   cur_in_buf;
  logic [OCC_W-1:0]   cur_in_buf_dec;
  logic [OCC_W-1:0]   cur_in_buf_acc;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [11:0]        cur_cnt;
  logic [11:0]        nxt_cnt;
  logic [11:0]        nxt_total;
  logic               push;
  logic               pop;
  logic               drop;
  logic               cur_pop;
  logic               flush_last;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Handshake: the sender has no backpressure, so a word is either pushed or
  // dropped in its valid cycle; the FIFO side writes whenever the head exists
  // and full is low (wr_en is the pop strobe).
  assign pop                = (occ != '0) && !us_timming_full_i;
  assign push               = us_timming_flow_vld_i && ((occ != OCC_FULL) || pop);
  assign drop               = us_timming_flow_vld_i && !push;
  assign us_timming_wr_en_o = pop;
  assign us_timming_din_o   = buf_mem[rd_ptr];
  assign state_dbg          = state;

  always_comb begin
    occ_next = occ;
    if (push && !pop)
      occ_next = occ + 1'b1;
    else if (pop && !push)
      occ_next = occ - 1'b1;
  end

  // Current-frame words always sit at the buffer head, ahead of next-frame words.
  assign cur_pop        = pop && (cur_in_buf != '0);
  assign cur_in_buf_dec = cur_in_buf - {{(OCC_W-1){1'b0}}, cur_pop};
  assign cur_in_buf_acc = cur_in_buf_dec + {{(OCC_W-1){1'b0}}, push};
  assign flush_last     = (cur_in_buf == '0) || ((cur_in_buf == OCC_W'(1)) && pop);
  assign nxt_total      = push ? sat_inc(nxt_cnt) : nxt_cnt;

  always_ff @(posedge sys_clk_i) begin
    if (push)
      buf_mem[wr_ptr] <= us_timming_flow_i;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_next;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF)
        drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state               <= S_IDLE;
      cur_in_buf          <= '0;
      idle_cnt            <= '0;
      cur_cnt             <= '0;
      nxt_cnt             <= '0;
      frame_word_cnt_o    <= '0;
      frame_done_pluse_o  <= 1'b0;
      frame_abort_pluse_o <= 1'b0;
    end else begin
      frame_done_pluse_o  <= 1'b0;
      frame_abort_pluse_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cur_in_buf <= cur_in_buf_acc;
          idle_cnt   <= '0;
          cur_cnt    <= {11'd0, push};
          if (transmit_done_pluse_i)
            state <= S_FLUSH;
          else if (push)
            state <= S_RECV;
        end
        S_RECV: begin
          cur_in_buf <= cur_in_buf_acc;
          if (push)
            cur_cnt <= sat_inc(cur_cnt);
          if (transmit_done_pluse_i) begin
            idle_cnt <= '0;
            state    <= S_FLUSH;
          end else if (us_timming_flow_vld_i) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            // Abandon the frame count; buffered words still drain to the FIFO.
            idle_cnt            <= '0;
            cur_cnt             <= '0;
            frame_abort_pluse_o <= 1'b1;
            state               <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          cur_in_buf <= cur_in_buf_dec;
          nxt_cnt    <= nxt_total;
          if (flush_last) begin
            frame_done_pluse_o <= 1'b1;
            frame_word_cnt_o   <= cur_cnt;
            state              <= S_DONE;
          end
        end
        S_DONE: begin
          // Everything still buffered belongs to the frame that starts now.
          cur_in_buf <= occ_next;
          cur_cnt    <= nxt_total;
          nxt_cnt    <= '0;
          idle_cnt   <= '0;
          state      <= (nxt_total != 12'd0) ? S_RECV : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_us_timming_flow_receiver.sv
// Bench for us_timming_flow_receiver: a queue model of accepted-but-unwritten
// words checks every FIFO write; scenario tasks check frame pulses and counters.
module tb_us_timming_flow_receiver;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic [W-1:0]  data;
  logic          done;
  logic          full;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          frame_done;
  logic [11:0]   frame_cnt;
  logic          frame_abort;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [1:0]    state_dbg;

  logic [W-1:0]  exp_q[$];
  int            model_drops;
  int            cyc;
  int            n_done;
  int            n_abort;
  int            n_writes;
  int            last_done_cyc;
  int            last_abort_cyc;
  int            checks;
  int            errors;

  us_timming_flow_receiver #(
    .DATA_W(W), .BUF_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk_i             (clk),
    .rst_i                 (rst),
    .us_timming_flow_vld_i (vld),
    .us_timming_flow_i     (data),
    .transmit_done_pluse_i (done),
    .us_timming_wr_en_o    (wr_en),
    .us_timming_din_o      (din),
    .us_timming_full_i     (full),
    .frame_done_pluse_o    (frame_done),
    .frame_word_cnt_o      (frame_cnt),
    .frame_abort_pluse_o   (frame_abort),
    .overflow_o            (overflow),
    .drop_cnt_o            (drop_cnt),
    .state_dbg             (state_dbg)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, check the FIFO write side at the falling
  // edge against the model queue, then advance the model over the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic dn, input logic f);
    logic exp_wr;
    vld = v; data = d; done = dn; full = f;
    @(negedge clk);
    cyc++;
    if (frame_done === 1'b1) begin n_done++; last_done_cyc = cyc; end
    if (frame_abort === 1'b1) begin n_abort++; last_abort_cyc = cyc; end
    exp_wr = (exp_q.size() > 0) && !f;
    checks++;
    if (wr_en !== exp_wr) begin
      errors++;
      $display("FAIL wr_en cyc %0d: got %b expected %b", cyc, wr_en, exp_wr);
    end
    if (exp_wr) begin
      checks++;
      if (din !== exp_q[0]) begin
        errors++;
        $display("FAIL din cyc %0d: got %0h expected %0h", cyc, din, exp_q[0]);
      end
      void'(exp_q.pop_front());
      n_writes++;
    end
    if (rst) begin
      exp_q.delete();
      model_drops = 0;
    end else if (v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else model_drops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Idle with full low until a new frame_done pulse appears (bounded).
  task automatic wait_done(input int d0);
    for (int i = 0; i < 40 && n_done == d0; i++) step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (n_done != d0 + 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected %0d", n_done - d0, 1);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; data = '0; done = 1'b0; full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("reset_overflow", {31'd0, overflow}, 32'd0);
    check_val("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check_val("reset_frame_cnt", {20'd0, frame_cnt}, 32'd0);
    check_val("reset_done_pulse", {31'd0, frame_done}, 32'd0);
    check_val("reset_abort_pulse", {31'd0, frame_abort}, 32'd0);
  endtask

  task automatic test_basic_12();
    int d0, w0;
    d0 = n_done; w0 = n_writes;
    for (int i = 0; i < 12; i++) step(1'b1, $urandom, (i == 11), 1'b0);
    wait_done(d0);
    idle(3);
    check_val("basic12_frame_cnt", {20'd0, frame_cnt}, 32'd12);
    check_val("basic12_writes", n_writes - w0, 32'd12);
    check_val("basic12_done_once", n_done - d0, 32'd1);
  endtask

  task automatic test_overflow();
    int d0, w0;
    d0 = n_done; w0 = n_writes;
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, (i == 7), 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check_val("ovf_no_write_while_full", n_writes - w0, 32'd0);
    wait_done(d0);
    idle(2);
    check_val("ovf_writes", n_writes - w0, 32'd4);
    check_val("ovf_frame_cnt", {20'd0, frame_cnt}, 32'd4);
    check_val("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    check_val("ovf_overflow", {31'd0, overflow}, 32'd1);
  endtask

  task automatic test_zero_frame();
    int d0, w0, c0;
    d0 = n_done; w0 = n_writes;
    step(1'b0, '0, 1'b1, 1'b0);
    c0 = cyc;
    wait_done(d0);
    idle(2);
    check_val("zero_done_latency", last_done_cyc - c0, 32'd2);
    check_val("zero_frame_cnt", {20'd0, frame_cnt}, 32'd0);
    check_val("zero_writes", n_writes - w0, 32'd0);
  endtask

  task automatic test_timeout();
    int d0, a0, w0, c0;
    d0 = n_done; a0 = n_abort; w0 = n_writes;
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    c0 = cyc;
    idle(TO + 6);
    check_val("timeout_writes", n_writes - w0, 32'd3);
    check_val("timeout_abort_once", n_abort - a0, 32'd1);
    check_val("timeout_abort_latency", last_abort_cyc - c0, 32'(TO + 1));
    check_val("timeout_no_done", n_done - d0, 32'd0);
  endtask

  task automatic test_flush_full();
    int d0;
    d0 = n_done;
    step(1'b1, $urandom, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'b1, 1'b1);
    step(1'b1, $urandom, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    check_val("flush_no_done_while_full", n_done - d0, 32'd0);
    wait_done(d0);
    check_val("flush_frame_cnt", {20'd0, frame_cnt}, 32'd2);
    idle(1);
    d0 = n_done;
    step(1'b1, $urandom, 1'b1, 1'b0);
    wait_done(d0);
    idle(2);
    check_val("flush_next_frame_cnt", {20'd0, frame_cnt}, 32'd3);
  endtask

  task automatic test_random();
    int n, acc, d0, gap;
    logic fl;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 10);
      acc = 0;
      d0 = n_done;
      for (int i = 0; i < n; i++) begin
        gap = (i == 0) ? 0 : $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0, ($urandom_range(0, 3) == 0));
        fl = ($urandom_range(0, 2) == 0);
        if (exp_q.size() < DEPTH || (exp_q.size() > 0 && !fl)) acc++;
        step(1'b1, $urandom, (i == n - 1), fl);
      end
      wait_done(d0);
      idle(2);
      check_val("rand_frame_cnt", {20'd0, frame_cnt}, 32'(acc));
      check_val("rand_drop_cnt", {16'd0, drop_cnt}, 32'(model_drops));
      check_val("rand_overflow", {31'd0, overflow}, {31'd0, model_drops > 0});
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    w0 = n_writes;
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    full = 1'b0;
    #1;
    check_val("rstmid_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("rstmid_overflow", {31'd0, overflow}, 32'd0);
    check_val("rstmid_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check_val("rstmid_frame_cnt", {20'd0, frame_cnt}, 32'd0);
    check_val("rstmid_pulses", {30'd0, frame_done, frame_abort}, 32'd0);
    idle(4);
    check_val("rstmid_no_writes", n_writes - w0, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; n_done = 0; n_abort = 0; n_writes = 0;
    last_done_cyc = 0; last_abort_cyc = 0; model_drops = 0;
    test_reset();
    test_basic_12();
    test_overflow();
    test_zero_frame();
    test_timeout();
    test_flush_full();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/us_timming_flow_receiver.md
US_TIMMING_FLOW_RECEIVER -- requirements
Module: us_timming_flow_receiver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, flow word width.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 4, skid-buffer entries (power of 2, >=2).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, idle cycles in RECV before frame abort.
REQ-004 sys_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 us_timming_flow_vld_i  in  1  qualifies one incoming flow word; no backpressure to sender.
REQ-007 us_timming_flow_i  in  DATA_W  incoming flow word.
REQ-008 transmit_done_pluse_i  in  1  one-cycle end-of-frame pulse from sender.
REQ-009 us_timming_wr_en_o  out  1  FIFO write strobe.
REQ-010 us_timming_din_o  out  DATA_W  FIFO write data.
REQ-011 us_timming_full_i  in  1  FIFO full; no write while high.
REQ-012 frame_done_pluse_o  out  1  one-cycle pulse when a frame is fully written to FIFO.
REQ-013 frame_word_cnt_o  out  12  words accepted in last completed frame.
REQ-014 frame_abort_pluse_o  out  1  one-cycle pulse on timeout abort.
REQ-015 overflow_o  out  1  sticky: at least one word dropped since reset.
REQ-016 drop_cnt_o  out  16  dropped-word count, saturating at 16'hFFFF.

Function
REQ-017 Skid buffer SHALL be a BUF_DEPTH-entry FIFO of registers with occupancy counter 0..BUF_DEPTH.
REQ-018 Push SHALL occur on every cycle us_timming_flow_vld_i=1 when occupancy<BUF_DEPTH or a pop occurs in the same cycle.
REQ-019 Pop SHALL occur when occupancy>0 and us_timming_full_i=0; us_timming_wr_en_o = (occupancy>0) & ~us_timming_full_i, combinational from registers and full.
REQ-020 us_timming_din_o SHALL be the buffer head word; value is don't-care when us_timming_wr_en_o=0.
REQ-021 Latency: word valid at edge N with empty buffer and full low SHALL appear with us_timming_wr_en_o=1 in cycle N+1.
REQ-022 Word order into FIFO SHALL equal arrival order; no duplication.
REQ-023 Valid word with occupancy=BUF_DEPTH and no pop SHALL be dropped, set overflow_o, increment drop_cnt_o (saturating), and not be counted in the frame.
REQ-024 States: IDLE, RECV, FLUSH, DONE.
REQ-025 IDLE: accepted word -> RECV, current count=1; transmit_done_pluse_i with no word -> FLUSH (zero-length frame).
REQ-026 RECV: each accepted word increments current count (saturate 4095); transmit_done_pluse_i -> FLUSH; word and done in same cycle SHALL count in current frame.
REQ-027 RECV: TIMEOUT_CYCLES consecutive cycles without vld and without done -> IDLE, pulse frame_abort_pluse_o, discard count, buffered words still written.
REQ-028 FLUSH: stay until all current-frame words popped; then -> DONE.
REQ-029 DONE (one cycle): pulse frame_done_pluse_o, load frame_word_cnt_o with frame count; -> RECV if next-frame words pending, else IDLE.
REQ-030 Words accepted in FLUSH/DONE SHALL count toward the next frame (separate next count), becoming current count on DONE exit.
REQ-031 transmit_done_pluse_i in FLUSH/DONE SHALL be ignored.

Reset
REQ-032 On rst_i=1 at an edge: state IDLE, buffer occupancy 0, counts 0, frame_word_cnt_o=0, drop_cnt_o=0, overflow_o=0, all pulses 0; us_timming_wr_en_o=0 the following cycle.
REQ-033 Reset mid-frame SHALL discard buffered words without writing them.

Verification
REQ-034 12 consecutive vld words, full low, done on last word cycle -> 12 writes in order, each 1 cycle after arrival, frame_done_pluse_o once, frame_word_cnt_o=12.
REQ-035 full high for 10 cycles during 8-word burst, BUF_DEPTH=4 -> first 4 words written after full drops, 4 dropped, overflow_o=1, drop_cnt_o=4, frame_word_cnt_o=4.
REQ-036 done pulse in IDLE, no words -> frame_done_pluse_o after 2 cycles, frame_word_cnt_o=0, no writes.
REQ-037 3 words then silence, TIMEOUT_CYCLES=16 -> 3 writes, frame_abort_pluse_o 16 cycles after last word, no frame_done_pluse_o.
REQ-038 done with full high, 2 new words during FLUSH -> frame_done only after full drops; next frame ends with frame_word_cnt_o including those 2 words.
REQ-039 rst_i asserted with 3 words buffered -> no further writes, all outputs at reset values next cycle.
